// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default sizing for the IR pulse timer.
package timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, SAT} state_e;
    localparam int DEF_WIDTH = 20;
    localparam logic [19:0] DEF_LIMIT = 20'h0FFFF;
    localparam int DEF_PRE_W = 8;
    localparam int DIV_1US_50MHZ = 50;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: runtime clock divider producing one tick_int per max(div,1) enabled clocks.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] div,
    output logic             tick_int
);
    logic [PRE_W-1:0] pre_q, pre_d, last;
    assign last = (div == '0) ? '0 : div - PRE_W'(1);
    // >= lets a shrinking div fire on the next clock instead of wrapping the counter
    assign tick_int = run && en && (pre_q >= last);
    always_comb begin
        pre_d = (clr || !run) ? '0 : !en ? pre_q : tick_int ? '0 : pre_q + PRE_W'(1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_q <= '0;
        else      pre_q <= pre_d;
    end
endmodule

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: prescaled interval timer with start/stop, capture and saturation.
// Build with TIMER_WRAP_EN to wrap at LIMIT with a one-cycle timeout pulse instead of saturating.
module ir_pulse_timer
    import timer_pkg::*;
#(
    parameter int               WIDTH          = DEF_WIDTH,
    parameter logic [WIDTH-1:0] LIMIT          = WIDTH'(DEF_LIMIT),
    parameter int               PRE_W          = DEF_PRE_W,
    parameter bit               RESTART_ON_CAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             capture,
    input  logic [PRE_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic [WIDTH-1:0] cap_count,
    output logic             cap_valid,
    output logic             timeout,
    output logic             running
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, cap_q, cap_d, inc;
    logic             tick_q, tick_d, capv_q, capv_d, clr, tick_int, restart;
`ifdef TIMER_WRAP_EN
    logic             wrap_q, wrap_d;
`endif

    timer_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q == RUN),
        .en       (en),
        .clr      (clr),
        .div      (div),
        .tick_int (tick_int)
    );

    assign inc     = count_q + WIDTH'(1);
    assign restart = capture && RESTART_ON_CAP && (state_q != IDLE);

    // Priority: stop > start > capture > tick
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cap_d   = cap_q;
        capv_d  = 1'b0;
        tick_d  = 1'b0;
        clr     = 1'b0;
`ifdef TIMER_WRAP_EN
        wrap_d  = 1'b0;
`endif
        if (stop) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else if (start) begin
            state_d = RUN;
            count_d = '0;
            clr     = 1'b1;
        end else begin
            if (capture) begin
                cap_d  = count_q;
                capv_d = 1'b1;
            end
            if (restart) begin
                state_d = RUN;
                count_d = '0;
                clr     = 1'b1;
            end else if (tick_int) begin
                tick_d = 1'b1;
`ifdef TIMER_WRAP_EN
                count_d = (inc == LIMIT) ? '0 : inc;
                wrap_d  = (inc == LIMIT);
`else
                count_d = inc;
                state_d = (inc == LIMIT) ? SAT : state_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            cap_q   <= '0;
            tick_q  <= 1'b0;
            capv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cap_q   <= cap_d;
            tick_q  <= tick_d;
            capv_q  <= capv_d;
        end
    end

`ifdef TIMER_WRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wrap_q <= 1'b0;
        else      wrap_q <= wrap_d;
    end
    assign timeout = wrap_q;
`else
    assign timeout = (state_q == SAT);
`endif

    assign count     = count_q;
    assign tick      = tick_q;
    assign cap_count = cap_q;
    assign cap_valid = capv_q;
    assign running   = (state_q == RUN);
endmodule
